// File: rtl/frequency_analyzer_scheduler_pkg.sv
// Shared definitions for the frequency analyzer window scheduler:
// FSM encoding, minimum window length and default timing constants.
package frequency_analyzer_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_START    = 3'd2,
    ST_MEASURE  = 3'd3,
    ST_STOP     = 3'd4,
    ST_WAIT_IRQ = 3'd5,
    ST_DONE     = 3'd6
  } sched_state_t;

  localparam int MIN_WINDOW_CYCLES          = 2;
  localparam int DEFAULT_CLEAR_CYCLES       = 4;
  localparam int DEFAULT_IRQ_TIMEOUT_CYCLES = 1024;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frequency_analyzer_scheduler_if.sv
// Control/status and analyzer-pin bundle between software registers,
// the scheduler and one frequency_analyzer_manager instance.
interface frequency_analyzer_scheduler_if #(
  parameter int WINDOW_WIDTH      = 32,
  parameter int CYCLE_COUNT_WIDTH = 16
);
  logic [WINDOW_WIDTH-1:0]      cfg_window_cycles;
  logic [CYCLE_COUNT_WIDTH-1:0] cfg_repeat;
  logic                         cmd_start;
  logic                         cmd_abort;
  logic                         analyzer_irq;
  logic                         analyzer_clear;
  logic                         analyzer_start;
  logic                         analyzer_stop;
  logic                         busy;
  logic                         window_done;
  logic [CYCLE_COUNT_WIDTH-1:0] windows_completed;
  logic                         timeout_error;
  logic [2:0]                   state;

  modport slave (
    input  cfg_window_cycles, cfg_repeat, cmd_start, cmd_abort, analyzer_irq,
    output analyzer_clear, analyzer_start, analyzer_stop, busy, window_done,
           windows_completed, timeout_error, state
  );

  modport master (
    output cfg_window_cycles, cfg_repeat, cmd_start, cmd_abort, analyzer_irq,
    input  analyzer_clear, analyzer_start, analyzer_stop, busy, window_done,
           windows_completed, timeout_error, state
  );
endinterface

// File: rtl/frequency_analyzer_scheduler_pulse_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// single-cycle rising-edge detect in the destination clock domain.
module pulse_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic async_in,
  output logic rise
);

  // [STAGES-1:0] is the synchronizer chain, the top bit holds the prior value
  logic [STAGES:0] sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-1:0], async_in};
    end
  end

  assign rise = sync_reg[STAGES-1] & ~sync_reg[STAGES];

endmodule

// File: rtl/frequency_analyzer_scheduler.sv
// Runs the analyzer through repeated clear/start/measure/stop windows,
// waits for its irq after each window and reports progress and timeouts.
module frequency_analyzer_scheduler
  import frequency_analyzer_scheduler_pkg::*;
#(
  parameter int WINDOW_WIDTH       = 32,
  parameter int CYCLE_COUNT_WIDTH  = 16,
  parameter int CLEAR_CYCLES       = DEFAULT_CLEAR_CYCLES,
  parameter int IRQ_TIMEOUT_CYCLES = DEFAULT_IRQ_TIMEOUT_CYCLES
) (
  input  logic                           s00_axi_aclk,
  input  logic                           reset,
  frequency_analyzer_scheduler_if.slave  sched
);

  localparam int CNT_W = max_int(WINDOW_WIDTH,
                                 max_int($clog2(CLEAR_CYCLES) + 1,
                                         $clog2(IRQ_TIMEOUT_CYCLES) + 1));
  localparam logic [CNT_W-1:0]        CLEAR_LOAD   = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0]        TIMEOUT_LOAD = CNT_W'(IRQ_TIMEOUT_CYCLES - 2);
  localparam logic [WINDOW_WIDTH-1:0] MIN_WIN      = WINDOW_WIDTH'(MIN_WINDOW_CYCLES);

  sched_state_t                 state_reg, state_next;
  logic [CNT_W-1:0]             cnt_reg, cnt_next;
  logic [WINDOW_WIDTH-1:0]      win_reg;
  logic [CYCLE_COUNT_WIDTH-1:0] repeat_reg;
  logic [CYCLE_COUNT_WIDTH-1:0] count_reg;
  logic                         timeout_reg;
  logic                         clear_reg, start_reg, stop_reg, done_reg, busy_reg;
  logic                         irq_rise;
  logic                         load_cfg, set_timeout, inc_count, abort_stop;

  pulse_edge_sync #(.STAGES(2)) u_irq_sync (
    .clk      (s00_axi_aclk),
    .srst     (reset),
    .async_in (sched.analyzer_irq),
    .rise     (irq_rise)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    load_cfg    = 1'b0;
    set_timeout = 1'b0;
    inc_count   = 1'b0;
    abort_stop  = 1'b0;
    if (sched.cmd_abort) begin
      // Only an analyzer that has been started needs an explicit stop
      state_next = ST_IDLE;
      abort_stop = (state_reg == ST_START) || (state_reg == ST_MEASURE);
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (sched.cmd_start) begin
            load_cfg   = 1'b1;
            state_next = ST_CLEAR;
            cnt_next   = CLEAR_LOAD;
          end
        end
        ST_CLEAR: begin
          if (cnt_reg == '0) state_next = ST_START;
          else               cnt_next   = cnt_reg - CNT_W'(1);
        end
        ST_START: begin
          // MEASURE spans W-1 cycles so STOP lands exactly W after START
          state_next = ST_MEASURE;
          cnt_next   = CNT_W'(win_reg - MIN_WIN);
        end
        ST_MEASURE: begin
          if (cnt_reg == '0) state_next = ST_STOP;
          else               cnt_next   = cnt_reg - CNT_W'(1);
        end
        ST_STOP: begin
          state_next = ST_WAIT_IRQ;
          cnt_next   = TIMEOUT_LOAD;
        end
        ST_WAIT_IRQ: begin
          if (irq_rise) begin
            state_next = ST_DONE;
            inc_count  = 1'b1;
          end else if (cnt_reg == '0) begin
            state_next  = ST_IDLE;
            set_timeout = 1'b1;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if ((repeat_reg == '0) || (count_reg < repeat_reg)) begin
            state_next = ST_CLEAR;
            cnt_next   = CLEAR_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      win_reg     <= MIN_WIN;
      repeat_reg  <= '0;
      count_reg   <= '0;
      timeout_reg <= 1'b0;
      clear_reg   <= 1'b0;
      start_reg   <= 1'b0;
      stop_reg    <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Pulse outputs are registered decodes of the next state
      clear_reg <= (state_next == ST_CLEAR);
      start_reg <= (state_next == ST_START);
      stop_reg  <= (state_next == ST_STOP) || abort_stop;
      done_reg  <= (state_next == ST_DONE);
      busy_reg  <= (state_next != ST_IDLE);
      if (load_cfg) begin
        win_reg     <= (sched.cfg_window_cycles < MIN_WIN) ? MIN_WIN : sched.cfg_window_cycles;
        repeat_reg  <= sched.cfg_repeat;
        count_reg   <= '0;
        timeout_reg <= 1'b0;
      end else begin
        if (inc_count && (count_reg != {CYCLE_COUNT_WIDTH{1'b1}})) begin
          count_reg <= count_reg + CYCLE_COUNT_WIDTH'(1);
        end
        if (set_timeout) begin
          timeout_reg <= 1'b1;
        end
      end
    end
  end

  assign sched.analyzer_clear    = clear_reg;
  assign sched.analyzer_start    = start_reg;
  assign sched.analyzer_stop     = stop_reg;
  assign sched.window_done       = done_reg;
  assign sched.busy              = busy_reg;
  assign sched.windows_completed = count_reg;
  assign sched.timeout_error     = timeout_reg;
  assign sched.state             = state_reg;

endmodule
